fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), is the bubble instruction.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 StallF  input  1  hazard unit holds the PC and blocks new imem requests.
REQ-006 StallD  input  1  hazard unit holds the IF/ID register.
REQ-007 FlushD  input  1  hazard unit loads a bubble into IF/ID.
REQ-008 PCSrcE  input  1  taken branch/jump resolved in Execute.
REQ-009 PCTargetE  input  32  redirect target.
REQ-010 imem_req  output  1  instruction memory request valid.
REQ-011 imem_addr  output  32  request address, word aligned.
REQ-012 imem_ready  input  1  response valid this cycle; a beat is imem_req & imem_ready.
REQ-013 imem_rdata  input  32  instruction word, valid in the beat cycle.
REQ-014 InstrD  output  32  IF/ID instruction, drives op/funct3/funct7b5 decode.
REQ-015 PCD  output  32  IF/ID PC.
REQ-016 PCPlus4D  output  32  PCD + 4.
REQ-017 ValidD  output  1  IF/ID holds a real instruction (0 = bubble).

Function
REQ-018 FSM states: ISSUE (no request outstanding), WAIT (request issued, no beat yet).
REQ-019 ISSUE: imem_req = !StallF & !buf_valid; imem_addr = PCF.
REQ-020 ISSUE, imem_req=1, imem_ready=0 -> latch req_addr = PCF, go WAIT.
REQ-021 WAIT: imem_req=1 and imem_addr=req_addr held stable regardless of StallF/PCSrcE until the beat; beat -> ISSUE.
REQ-022 Good beat (not dropped, PCSrcE=0): PCF <= beat address + 4; instruction delivered per REQ-025.
REQ-023 PCSrcE=1: PCF <= PCTargetE; buf_valid <= 0; a beat in the same cycle is discarded; in WAIT without beat, drop <= 1.
REQ-024 Beat with drop=1: data discarded, PCF unchanged, drop <= 0.
REQ-025 Delivery: StallD=0 -> IF/ID loads {rdata, addr, addr+4}, ValidD=1; StallD=1 -> one-entry skid buffer stores it, buf_valid <= 1.
REQ-026 IF/ID update priority: FlushD -> {NOP_INSTR, PCD, PCPlus4D held}, ValidD=0; else StallD -> hold; else buf_valid -> load buffer, buf_valid <= 0; else good beat -> load beat; else bubble (NOP_INSTR, ValidD=0).
REQ-027 StallF=1 in ISSUE: no request, PCF held; StallF does not affect WAIT.
REQ-028 PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-029 Fetch-to-decode latency: beat in cycle N -> InstrD valid in N+1 with zero imem wait states; throughput one instruction/cycle.

Reset
REQ-030 reset=0 asynchronously forces: PCF=RESET_PC, state=ISSUE, drop=0, buf_valid=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
REQ-031 imem_req=0 while reset=0; first request at RESET_PC in the first cycle after release.
REQ-032 Reset during WAIT abandons the request; the late beat is ignored because imem_req was deasserted.

Structure
REQ-033 Shared package riscv_pkg holds NOP_INSTR, default RESET_PC, fetch FSM state enum.
REQ-034 Skid buffer is a sub-module fetch_skid_buf (one entry: instr, pc, valid; load/clear/pop ports).

Verification
REQ-035 Release reset, imem_ready=1 constant, rdata=addr -> imem_addr 0,4,8; InstrD=0 at cycle 2, ValidD=1.
REQ-036 imem_ready=0 three cycles at addr 8 -> imem_addr stays 8, ValidD=0 for three cycles, then InstrD=8.
REQ-037 PCSrcE=1, PCTargetE=0x100 during WAIT at addr 0x10 -> 0x10 beat dropped, next imem_addr=0x100, never InstrD from 0x10.
REQ-038 StallD=1 while beat at 0x20 arrives -> buffered; StallD=0 next cycle -> InstrD from 0x20, imem_req low while buffered.
REQ-039 FlushD=1 with StallD=1 -> InstrD=0x00000013, ValidD=0.
REQ-040 RESET_PC=0xFFFFFFFC -> second fetch address 0x00000000; reset=0 mid-WAIT -> outputs at reset values asynchronously.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V fetch front end.
package riscv_pkg;

  localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RV_RESET_PC  = 32'h0000_0000;

  typedef enum logic {
    F_ISSUE = 1'b0,
    F_WAIT  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding slot for an instruction that returned while decode was stalled.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic        pop,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        valid
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (load) begin
      instr_d = load_instr;
      pc_d    = load_pc;
      valid_d = 1'b1;
    end else if (clear || pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc    = pc_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem request handshake, redirect squash and IF/ID register.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RV_RESET_PC,
  parameter logic [31:0] NOP_INSTR = RV_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pcf_q, pcf_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic         drop_q, drop_d;
  logic [31:0]  instrd_q, instrd_d;
  logic [31:0]  pcd_q, pcd_d;
  logic [31:0]  pcplus4d_q, pcplus4d_d;
  logic         validd_q, validd_d;

  logic         beat, good_beat;
  logic         buf_valid, buf_load, buf_pop;
  logic [31:0]  buf_instr, buf_pc;

  // Request is gated by reset so nothing is issued while reset is held.
  always_comb begin
    if (state_q == F_WAIT) begin
      imem_req  = reset;
      imem_addr = req_addr_q;
    end else begin
      imem_req  = reset & ~StallF & ~buf_valid;
      imem_addr = pcf_q;
    end
  end

  assign beat      = imem_req & imem_ready;
  assign good_beat = beat & ~PCSrcE & ~drop_q;
  assign buf_load  = good_beat & StallD;
  assign buf_pop   = buf_valid & ~FlushD & ~StallD;

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    drop_d     = drop_q;
    pcf_d      = pcf_q;
    case (state_q)
      F_ISSUE: begin
        // A redirect alongside a fresh miss marks that request stale immediately.
        if (imem_req && !imem_ready) begin
          state_d    = F_WAIT;
          req_addr_d = pcf_q;
          drop_d     = PCSrcE;
        end
      end
      F_WAIT: begin
        if (imem_ready) begin
          state_d = F_ISSUE;
          drop_d  = 1'b0;
        end else if (PCSrcE) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = F_ISSUE;
    endcase
    if (PCSrcE)         pcf_d = PCTargetE;
    else if (good_beat) pcf_d = imem_addr + 32'd4;
  end

  always_comb begin
    instrd_d   = instrd_q;
    pcd_d      = pcd_q;
    pcplus4d_d = pcplus4d_q;
    validd_d   = validd_q;
    if (FlushD) begin
      instrd_d = NOP_INSTR;
      validd_d = 1'b0;
    end else if (!StallD) begin
      if (buf_valid) begin
        instrd_d   = buf_instr;
        pcd_d      = buf_pc;
        pcplus4d_d = buf_pc + 32'd4;
        validd_d   = 1'b1;
      end else if (good_beat) begin
        instrd_d   = imem_rdata;
        pcd_d      = imem_addr;
        pcplus4d_d = imem_addr + 32'd4;
        validd_d   = 1'b1;
      end else begin
        instrd_d = NOP_INSTR;
        validd_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= F_ISSUE;
      pcf_q      <= RESET_PC;
      req_addr_q <= '0;
      drop_q     <= 1'b0;
      instrd_q   <= NOP_INSTR;
      pcd_q      <= '0;
      pcplus4d_q <= '0;
      validd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcf_q      <= pcf_d;
      req_addr_q <= req_addr_d;
      drop_q     <= drop_d;
      instrd_q   <= instrd_d;
      pcd_q      <= pcd_d;
      pcplus4d_q <= pcplus4d_d;
      validd_q   <= validd_d;
    end
  end

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst_n      (reset),
    .load       (buf_load),
    .clear      (PCSrcE),
    .pop        (buf_pop),
    .load_instr (imem_rdata),
    .load_pc    (imem_addr),
    .instr      (buf_instr),
    .pc         (buf_pc),
    .valid      (buf_valid)
  );

  assign InstrD   = instrd_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcplus4d_q;
  assign ValidD   = validd_q;

endmodule
